window_magnitude: RTL and testbench

Parametrised successor to the single-channel peak/offset detector. It measures max, min, peak-to-peak amplitude, mid-point DC offset and true mean of an ADC sample stream over a fixed window of 2^WIN_LOG2 accepted samples.
- Adds a sample-valid qualifier, a signed-data mode, overflow-safe arithmetic and a synchronous restart.
- Results are published once per window with a one-cycle valid pulse.
- Sits between the ADC capture interface and downstream display/control logic.

---
 rtl/window_magnitude.sv | 130 +++++++++++++
 tb/tb_window_magnitude.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window_magnitude.sv
// Windowed max/min/amplitude/mid-point/mean of a sample stream.
// in: clk rst_n sample_in sample_valid clear; out: max_out min_out amp dc_offset mean result_valid
module window_magnitude #(
  parameter int DATA_W   = 12,
  parameter int WIN_LOG2 = 10,
  parameter int SIGNED   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] amp,
  output logic [DATA_W-1:0] dc_offset,
  output logic [DATA_W-1:0] mean,
  output logic              result_valid
);

  localparam int ACC_W = DATA_W + WIN_LOG2;
  localparam bit SGN   = (SIGNED != 0);
  // Flipping the MSB maps two's-complement order onto unsigned order.
  localparam logic [DATA_W-1:0] FLIP = {SGN, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic [DATA_W-1:0]   dc_q, dc_d;
  logic [DATA_W-1:0]   mean_q, mean_d;
  logic                rv_q, rv_d;

  logic [ACC_W-1:0]    samp_ext;
  logic [DATA_W:0]     mid_sum;
  logic                close;

  always_comb begin
    samp_ext  = {{WIN_LOG2{SGN & sample_in[DATA_W-1]}}, sample_in};
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    close     = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      first_d = 1'b1;
      acc_d   = '0;
    end else if (sample_valid) begin
      if (first_q) begin
        run_max_d = sample_in;
        run_min_d = sample_in;
        acc_d     = samp_ext;
      end else begin
        if ((sample_in ^ FLIP) > (run_max_q ^ FLIP))
          run_max_d = sample_in;
        if ((sample_in ^ FLIP) < (run_min_q ^ FLIP))
          run_min_d = sample_in;
        acc_d = acc_q + samp_ext;
      end
      cnt_d   = cnt_q + 1'b1;
      first_d = 1'b0;
      if (cnt_q == '1) begin
        close   = 1'b1;
        first_d = 1'b1;
      end
    end
  end

  // One extra bit keeps the mid-point sum from wrapping.
  always_comb begin
    mid_sum = {SGN & run_max_d[DATA_W-1], run_max_d}
            + {SGN & run_min_d[DATA_W-1], run_min_d};
    max_d   = max_q;
    min_d   = min_q;
    amp_d   = amp_q;
    dc_d    = dc_q;
    mean_d  = mean_q;
    rv_d    = 1'b0;
    if (close) begin
      max_d  = run_max_d;
      min_d  = run_min_d;
      amp_d  = run_max_d - run_min_d;
      dc_d   = DATA_W'(mid_sum >> 1);
      mean_d = acc_d[ACC_W-1:WIN_LOG2];
      rv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_max_q <= '0;
      run_min_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      max_q     <= '0;
      min_q     <= '0;
      amp_q     <= '0;
      dc_q      <= '0;
      mean_q    <= '0;
      rv_q      <= 1'b0;
    end else begin
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      max_q     <= max_d;
      min_q     <= min_d;
      amp_q     <= amp_d;
      dc_q      <= dc_d;
      mean_q    <= mean_d;
      rv_q      <= rv_d;
    end
  end

  assign max_out      = max_q;
  assign min_out      = min_q;
  assign amp          = amp_q;
  assign dc_offset    = dc_q;
  assign mean         = mean_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_window_magnitude.sv
// Directed bench for window_magnitude.
// Unsigned and signed instances share one stimulus stream.
module tb_window_magnitude;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear = 1'b0;

  logic [11:0] max_u, min_u, amp_u, dc_u, mean_u;
  logic        rv_u;
  logic [11:0] max_s, min_s, amp_s, dc_s, mean_s;
  logic        rv_s;

  int n_cmp = 0;
  int n_err = 0;
  int pulses_u = 0;
  int p0;

  always #5 clk = ~clk;

  always @(negedge clk) if (rv_u) pulses_u++;

  window_magnitude #(.DATA_W(12), .WIN_LOG2(2), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
    .sample_valid(sample_valid), .clear(clear),
    .max_out(max_u), .min_out(min_u), .amp(amp_u),
    .dc_offset(dc_u), .mean(mean_u), .result_valid(rv_u)
  );

  window_magnitude #(.DATA_W(12), .WIN_LOG2(2), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
    .sample_valid(sample_valid), .clear(clear),
    .max_out(max_s), .min_out(min_s), .amp(amp_s),
    .dc_offset(dc_s), .mean(mean_s), .result_valid(rv_s)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] s, input bit clr = 1'b0);
    @(negedge clk);
    sample_in    = s;
    sample_valid = 1'b1;
    clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      clear        = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_u(input string tag,
                       input logic [11:0] mx, input logic [11:0] mn,
                       input logic [11:0] am, input logic [11:0] dc,
                       input logic [11:0] me);
    check({tag, ".max"}, max_u, mx);
    check({tag, ".min"}, min_u, mn);
    check({tag, ".amp"}, amp_u, am);
    check({tag, ".dc"}, dc_u, dc);
    check({tag, ".mean"}, mean_u, me);
  endtask

  task automatic w1(input int g0, input int g1, input int g2);
    send(12'd100);
    idle(g0);
    send(12'd400);
    idle(g1);
    send(12'd250);
    idle(g2);
    send(12'd300);
  endtask

  initial begin
    // reset
    idle(2);
    check("rst.rv_u", rv_u, 0);
    check("rst.rv_s", rv_s, 0);
    chk_u("rst", 0, 0, 0, 0, 0);
    check("rst.max_s", max_s, 0);
    rst_n = 1'b1;
    idle(1);

    // basic unsigned window
    p0 = pulses_u;
    send(12'd100);
    send(12'd400);
    send(12'd250);
    check("w1.early_rv", rv_u, 0);
    send(12'd300);
    check("w1.rv", rv_u, 1);
    chk_u("w1", 400, 100, 300, 250, 262);
    idle(1);
    check("w1.rv_off", rv_u, 0);
    check("w1.pulses", pulses_u - p0, 1);
    check("w1.hold", max_u, 400);

    // full-scale: no wrap in sum or mid-point
    send(12'd4095);
    send(12'd0);
    send(12'd4095);
    send(12'd0);
    check("fs.rv", rv_u, 1);
    chk_u("fs", 4095, 0, 4095, 2047, 2047);
    idle(1);

    // signed window: -100, 50, -20, 10
    send(12'hF9C);
    send(12'h032);
    send(12'hFEC);
    send(12'h00A);
    check("sg.rv", rv_s, 1);
    check("sg.max", max_s, 12'h032);
    check("sg.min", min_s, 12'hF9C);
    check("sg.amp", amp_s, 12'h096);
    check("sg.dc", dc_s, 12'hFE7);
    check("sg.mean", mean_s, 12'hFF1);
    idle(2);

    // gaps of 0, 1 and 3 cycles, then back-to-back window
    p0 = pulses_u;
    w1(0, 1, 3);
    check("gap.rv", rv_u, 1);
    chk_u("gap", 400, 100, 300, 250, 262);
    send(12'd10);
    send(12'd10);
    send(12'd10);
    send(12'd10);
    check("b2b.rv", rv_u, 1);
    chk_u("b2b", 10, 10, 0, 10, 10);
    idle(1);
    check("b2b.pulses", pulses_u - p0, 2);

    // clear mid-window
    w1(0, 0, 0);
    idle(1);
    p0 = pulses_u;
    send(12'd4000);
    send(12'd5);
    send(12'd3000, 1'b1);
    check("clr.rv", rv_u, 0);
    chk_u("clr.hold", 400, 100, 300, 250, 262);
    send(12'd20);
    send(12'd30);
    send(12'd40);
    check("clr.rv2", rv_u, 0);
    check("clr.hold2", max_u, 400);
    send(12'd50);
    check("clr.rv3", rv_u, 1);
    chk_u("clr", 50, 20, 30, 35, 35);
    idle(1);
    check("clr.pulses", pulses_u - p0, 1);

    // reset mid-window
    p0 = pulses_u;
    send(12'd1);
    send(12'd2);
    send(12'd3);
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst.rv", rv_u, 0);
    chk_u("mrst", 0, 0, 0, 0, 0);
    send(12'd7);
    send(12'd9);
    send(12'd8);
    check("mrst.early", rv_u, 0);
    send(12'd6);
    check("mrst.rv2", rv_u, 1);
    chk_u("mrst2", 9, 6, 3, 7, 7);
    idle(1);
    check("mrst.pulses", pulses_u - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
